// File: rtl/btn_debounce.sv
// btn_debounce: per-bit synchronizer plus stability counter for raw
// push-button inputs. btn_clean feeds the LED decoder btn input directly.
// Optional feature: define BTN_EDGE_EN to build the registered one-cycle
// btn_rise / btn_fall pulses; without it both ports are tied to 0.
module btn_debounce #(
    parameter int WIDTH       = 4,
    parameter int CNT_MAX     = 1000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_clean,
    output logic [WIDTH-1:0] btn_rise,
    output logic [WIDTH-1:0] btn_fall
);

    localparam int            CW       = $clog2(CNT_MAX + 1);
    // Last count value before a new level is accepted.
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [CW-1:0]    cnt_d  [WIDTH];
    logic [WIDTH-1:0] clean_d;

    // Plain flop chain bringing each asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every stage is cleared, including the array; these are
            // individual flops, not a RAM, so a reset costs nothing extra.
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let each stage take the old value
            // of the previous one, which is what makes this a shift chain.
            sync_q[0] <= btn_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Per-bit stability count: a new level is accepted only after CNT_MAX
    // consecutive cycles of disagreement; any agreement restarts from zero.
    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        clean_d = btn_clean;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync[i] != btn_clean[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    clean_d[i] = sync[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Counter and debounced-level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_clean <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            btn_clean <= clean_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef BTN_EDGE_EN
    // Edge pulses register alongside btn_clean so they line up with its change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_rise <= '0;
            btn_fall <= '0;
        end else begin
            btn_rise <= clean_d & ~btn_clean;
            btn_fall <= ~clean_d & btn_clean;
        end
    end
`else
    assign btn_rise = '0;
    assign btn_fall = '0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: vector table, hand sequences and random stimulus checked
// against a window-based reference model (CNT_MAX=4, SYNC_STAGES=2).
module tb_btn_debounce;

    localparam int W    = 4;
    localparam int CNT  = 4;
    localparam int SYNC = 2;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] btn_raw;
    logic [W-1:0] btn_clean;
    logic [W-1:0] btn_rise;
    logic [W-1:0] btn_fall;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    btn_debounce #(
        .WIDTH      (W),
        .CNT_MAX    (CNT),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .btn_clean(btn_clean),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raw samples delayed SYNC edges form the synchronized
    // stream; a bit flips when the last CNT synchronized samples all differ
    // from the current clean level.
    typedef struct packed {
        logic [CNT-1:0][W-1:0]  win;
        logic [SYNC-1:0][W-1:0] sp;
        logic [W-1:0]           clean;
        logic [W-1:0]           rise;
        logic [W-1:0]           fall;
    } model_t;

    model_t m;

    function automatic model_t model_next(input model_t cur_m, input logic [W-1:0] raw);
        model_t n;
        logic   all_diff;
        n = cur_m;
        for (int s = SYNC - 1; s > 0; s--) n.sp[s] = cur_m.sp[s-1];
        n.sp[0] = raw;
        for (int k = CNT - 1; k > 0; k--) n.win[k] = cur_m.win[k-1];
        n.win[0] = cur_m.sp[SYNC-1];
        n.rise = '0;
        n.fall = '0;
        for (int i = 0; i < W; i++) begin
            all_diff = 1'b1;
            for (int k = 0; k < CNT; k++) begin
                if (n.win[k][i] == cur_m.clean[i]) all_diff = 1'b0;
            end
            if (all_diff) begin
                n.clean[i] = ~cur_m.clean[i];
                if (n.clean[i]) n.rise[i] = 1'b1;
                else            n.fall[i] = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_next(m, btn_raw);
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_clean", btn_clean, m.clean);
`ifdef BTN_EDGE_EN
            check("model_rise", btn_rise, m.rise);
            check("model_fall", btn_fall, m.fall);
`else
            check("model_rise", btn_rise, '0);
            check("model_fall", btn_fall, '0);
`endif
        end
    end

    // Bit-2 activity counters used by the bounce sequence.
    int  rise2_cnt  = 0;
    int  trans2_cnt = 0;
    logic prev2     = 1'b0;

    task automatic tick();
        @(negedge clk);
        if (btn_rise[2] === 1'b1) rise2_cnt++;
        if (btn_clean[2] !== prev2) trans2_cnt++;
        prev2 = btn_clean[2];
    endtask

    typedef struct {
        logic [W-1:0] raw;
        int           hold;
        logic [W-1:0] exp_clean;
    } vec_t;

    vec_t tab[13];

    initial begin
        logic [W-1:0] pat;
        int           exp_rise;

        tab[0]  = '{4'b1111, 5, 4'b0000};
        tab[1]  = '{4'b1111, 1, 4'b1111};
        tab[2]  = '{4'b0000, 5, 4'b1111};
        tab[3]  = '{4'b0000, 1, 4'b0000};
        tab[4]  = '{4'b0010, 3, 4'b0000};
        tab[5]  = '{4'b0000, 6, 4'b0000};
        tab[6]  = '{4'b0010, 4, 4'b0000};
        tab[7]  = '{4'b0000, 2, 4'b0010};
        tab[8]  = '{4'b0000, 3, 4'b0010};
        tab[9]  = '{4'b0000, 1, 4'b0000};
        tab[10] = '{4'b0001, 2, 4'b0000};
        tab[11] = '{4'b1001, 4, 4'b0001};
        tab[12] = '{4'b1001, 2, 4'b1001};

        // Reset with all buttons pressed.
        rst_n   = 1'b0;
        btn_raw = 4'b1111;
        repeat (3) @(negedge clk);
        check("rst_clean", btn_clean, '0);
        check("rst_rise", btn_rise, '0);
        check("rst_fall", btn_fall, '0);
        chk_en = 1'b1;
        rst_n  = 1'b1;

        // Vector table: hold each raw pattern, then compare btn_clean.
        for (int e = 0; e < 13; e++) begin
            btn_raw = tab[e].raw;
            repeat (tab[e].hold) tick();
            check($sformatf("vec%0d", e), btn_clean, tab[e].exp_clean);
        end

        // Reset mid-count: bit 1 counting, clean=1001 must clear at once.
        btn_raw = 4'b1011;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_clean", btn_clean, '0);
        check("midrst_rise", btn_rise, '0);
        check("midrst_fall", btn_fall, '0);
        btn_raw = 4'b0010;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("fresh_cnt_early", btn_clean, 4'b0000);
        tick();
        check("fresh_cnt_done", btn_clean, 4'b0010);

        // Bounce on bit 2: 1,0,1,0,1 then hold 1.
        prev2      = btn_clean[2];
        rise2_cnt  = 0;
        trans2_cnt = 0;
        pat        = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            pat[2]  = (k % 2 == 0);
            btn_raw = pat;
            tick();
        end
        btn_raw = 4'b0110;
        repeat (4) tick();
        check("bounce_early", btn_clean, 4'b0010);
        tick();
        check("bounce_accept", btn_clean, 4'b0110);
        repeat (10) tick();
        check("bounce_trans", W'(trans2_cnt), W'(1));
`ifdef BTN_EDGE_EN
        exp_rise = 1;
`else
        exp_rise = 0;
`endif
        check("bounce_rise", W'(rise2_cnt), W'(exp_rise));

        // Random stimulus: occasional single-bit toggles, including glitches.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) btn_raw[$urandom_range(0, W-1)] ^= 1'b1;
            tick();
        end

        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
